// File: rtl/adc_spi_rx.sv
// Serial ADC receiver: generates a divided SCLK and chip-select framing, shifts
// in MSB-first data and hands parallel samples to the FIR over valid/ready.
module adc_spi_rx #(
    parameter int DATA_W     = 12,
    parameter int FRAME_BITS = 16,
    parameter int DIV        = 2,
    parameter int CS_GAP     = 4
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              en,
    input  logic              adc_miso,
    output logic              adc_sclk,
    output logic              adc_cs_n,
    output logic [DATA_W-1:0] sample_data,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              overrun
);

    localparam int CNT_MAX = (DIV > CS_GAP) ? DIV : CS_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = $clog2(FRAME_BITS + 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        GAP
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [FRAME_BITS-1:0] shift_reg;
    logic                  half_done;
    logic                  gap_done;

    assign half_done = (cnt == CNT_W'(DIV - 1));
    assign gap_done  = (cnt == CNT_W'(CS_GAP - 1));

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            adc_cs_n     <= 1'b1;
            adc_sclk     <= 1'b0;
            sample_data  <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            overrun <= 1'b0;
            // NOTE: the last non-blocking assignment wins, so a sample load at GAP
            // entry below overrides this accept-clear in the same cycle.
            if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (en) begin
                        state    <= SETUP;
                        adc_cs_n <= 1'b0;
                    end
                end

                SETUP: begin
                    if (half_done) begin
                        state   <= SHIFT;
                        cnt     <= '0;
                        bit_cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // adc_sclk itself tells which half of the bit period is running
                SHIFT: begin
                    if (!half_done) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt <= '0;
                        if (!adc_sclk) begin
                            adc_sclk  <= 1'b1;
                            shift_reg <= (shift_reg << 1) | FRAME_BITS'(adc_miso);
                        end else begin
                            adc_sclk <= 1'b0;
                            if (bit_cnt == BIT_W'(FRAME_BITS - 1)) begin
                                state        <= GAP;
                                adc_cs_n     <= 1'b1;
                                sample_data  <= shift_reg[DATA_W-1:0];
                                sample_valid <= 1'b1;
                                overrun      <= sample_valid && !sample_ready;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                end

                GAP: begin
                    if (gap_done) begin
                        cnt <= '0;
                        if (en) begin
                            state    <= SETUP;
                            adc_cs_n <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_spi_rx.sv
// Bench for adc_spi_rx: frame vector table, corner-case sequences and a random
// phase, all checked cycle by cycle against a frame-timing reference model.
module tb_adc_spi_rx;

    localparam int DATA_W     = 12;
    localparam int FRAME_BITS = 16;
    localparam int DIV        = 2;
    localparam int CS_GAP     = 4;
    localparam int LOAD_K     = DIV * (1 + 2 * FRAME_BITS);
    localparam int FRAME_K    = LOAD_K + CS_GAP;

    logic              clk_in = 1'b0;
    logic              reset;
    logic              en;
    logic              adc_miso;
    logic              adc_sclk;
    logic              adc_cs_n;
    logic [DATA_W-1:0] sample_data;
    logic              sample_valid;
    logic              sample_ready;
    logic              overrun;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit model_on = 1'b0;

    logic [FRAME_BITS-1:0] word_q[$];
    logic [FRAME_BITS-1:0] cur_word = '0;

    typedef struct {
        logic [FRAME_BITS-1:0] word;
        int                    mode;      // 0: ready low, 1: ready high, 2: ready only in load cycle
        logic [DATA_W-1:0]     exp_data;
        logic                  exp_ovr;
    } frame_vec_t;

    frame_vec_t vecs[9];

    adc_spi_rx #(
        .DATA_W    (DATA_W),
        .FRAME_BITS(FRAME_BITS),
        .DIV       (DIV),
        .CS_GAP    (CS_GAP)
    ) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .en          (en),
        .adc_miso    (adc_miso),
        .adc_sclk    (adc_sclk),
        .adc_cs_n    (adc_cs_n),
        .sample_data (sample_data),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .overrun     (overrun)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk_in);
        cyc++;
    endtask

    task automatic wait_cs_fall(output int at);
        logic prev;
        bit   found = 1'b0;
        at = -1;
        for (int i = 0; i < 200 && !found; i++) begin
            prev = adc_cs_n;
            tick();
            if (prev === 1'b1 && adc_cs_n === 1'b0) begin
                found = 1'b1;
                at    = cyc;
            end
        end
        check("cs_fall_seen", 32'(found), 32'd1);
    endtask

    // ADC model: MSB on chip-select fall, next bit after every SCLK falling edge
    initial begin : miso_drv
        logic prev_cs;
        logic prev_sclk;
        int   idx;
        prev_cs   = 1'b1;
        prev_sclk = 1'b0;
        idx       = 0;
        adc_miso  = 1'b0;
        forever begin
            @(posedge clk_in);
            #1;
            if (prev_cs === 1'b1 && adc_cs_n === 1'b0) begin
                cur_word = (word_q.size() > 0) ? word_q.pop_front() : FRAME_BITS'($urandom);
                idx      = FRAME_BITS - 1;
                adc_miso = cur_word[idx];
            end else if (prev_sclk === 1'b1 && adc_sclk === 1'b0 && idx > 0) begin
                idx--;
                adc_miso = cur_word[idx];
            end
            prev_cs   = adc_cs_n;
            prev_sclk = adc_sclk;
        end
    end

    // Reference model: frame position k = edges since chip-select fell
    initial begin : ref_model
        int                e;
        int                f;
        int                k;
        bit                active;
        bit                m_valid;
        bit                m_ovr;
        bit                load;
        logic [DATA_W-1:0] m_data;
        logic              r, en_s, rdy, exp_cs, exp_sclk;
        logic [15:0]       exp_v, act_v;
        e = 0; f = 0; active = 1'b0; m_valid = 1'b0; m_ovr = 1'b0; m_data = '0;
        forever begin
            @(posedge clk_in);
            r = reset; en_s = en; rdy = sample_ready;
            e++;
            if (r === 1'b1) begin
                model_on = 1'b1;
                active   = 1'b0;
                m_valid  = 1'b0;
                m_ovr    = 1'b0;
                m_data   = '0;
            end else if (model_on) begin
                k     = e - f;
                load  = active && (k == LOAD_K);
                m_ovr = load && m_valid && !rdy;
                if (load) begin
                    m_data  = cur_word[DATA_W-1:0];
                    m_valid = 1'b1;
                end else if (m_valid && rdy) begin
                    m_valid = 1'b0;
                end
                if (!active) begin
                    if (en_s) begin
                        active = 1'b1;
                        f      = e;
                    end
                end else if (k == FRAME_K) begin
                    if (en_s) f = e;
                    else      active = 1'b0;
                end
            end
            @(negedge clk_in);
            if (model_on) begin
                k        = e - f;
                exp_cs   = !(active && k < LOAD_K);
                exp_sclk = active && k >= DIV && k < LOAD_K && ((k - DIV) % (2 * DIV)) >= DIV;
                exp_v    = {exp_cs, exp_sclk, m_valid, m_ovr, m_data};
                act_v    = {adc_cs_n, adc_sclk, sample_valid, overrun, sample_data};
                check("cycle{cs_n,sclk,valid,ovr,data}", 32'(act_v), 32'(exp_v));
            end
        end
    end

    task automatic run_frame(input frame_vec_t v, input int prev_fall, output int fall);
        int   rises;
        int   first_rise;
        logic prev_sclk;
        rises      = 0;
        first_rise = -1;
        word_q.push_back(v.word);
        sample_ready = (v.mode == 1);
        wait_cs_fall(fall);
        if (prev_fall >= 0) check("frame_period", 32'(fall - prev_fall), 32'(FRAME_K));
        for (int k = 1; k < LOAD_K; k++) begin
            prev_sclk = adc_sclk;
            tick();
            if (prev_sclk === 1'b0 && adc_sclk === 1'b1) begin
                rises++;
                if (first_rise < 0) first_rise = k;
            end
            if (v.mode == 2 && k == LOAD_K - 1) sample_ready = 1'b1;
        end
        tick();
        check("load_data", 32'(sample_data), 32'(v.exp_data));
        check("load_valid", 32'(sample_valid), 32'd1);
        check("load_overrun", 32'(overrun), 32'(v.exp_ovr));
        check("load_cs_n_high", 32'(adc_cs_n), 32'd1);
        check("sclk_rises", 32'(rises), 32'(FRAME_BITS));
        check("first_rise_k", 32'(first_rise), 32'(2 * DIV));
        if (v.mode == 2) sample_ready = 1'b0;
        tick();
        check("valid_after_load", 32'(sample_valid), 32'(v.mode != 1));
        check("overrun_after_load", 32'(overrun), 32'd0);
    endtask

    initial begin : main
        int prev_fall;
        int fall;
        int bad;
        int rst_at;

        vecs[0] = '{16'h0A5C, 0, 12'hA5C, 1'b0};
        vecs[1] = '{16'hF001, 1, 12'h001, 1'b0};
        vecs[2] = '{16'h7FFF, 1, 12'hFFF, 1'b0};
        vecs[3] = '{16'h3800, 1, 12'h800, 1'b0};
        vecs[4] = '{16'h0123, 0, 12'h123, 1'b0};
        vecs[5] = '{16'h0456, 0, 12'h456, 1'b1};
        vecs[6] = '{16'hA123, 1, 12'h123, 1'b0};
        vecs[7] = '{16'hB123, 0, 12'h123, 1'b0};
        vecs[8] = '{16'hC456, 2, 12'h456, 1'b0};

        reset        = 1'b1;
        en           = 1'b0;
        sample_ready = 1'b0;
        repeat (3) tick();
        check("rst_cs_n", 32'(adc_cs_n), 32'd1);
        check("rst_sclk", 32'(adc_sclk), 32'd0);
        check("rst_data", 32'(sample_data), 32'd0);
        check("rst_valid", 32'(sample_valid), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        reset = 1'b0;
        en    = 1'b1;

        prev_fall = -1;
        for (int i = 0; i < 9; i++) begin
            run_frame(vecs[i], prev_fall, fall);
            prev_fall = fall;
        end

        // en dropped during bit 5: frame completes, then the interface stays idle
        word_q.push_back(16'h6E21);
        sample_ready = 1'b1;
        wait_cs_fall(fall);
        check("frame_period", 32'(fall - prev_fall), 32'(FRAME_K));
        sample_ready = 1'b0;
        for (int k = 1; k <= LOAD_K; k++) begin
            tick();
            if (k == DIV + 2 * DIV * 5 + 1) en = 1'b0;
        end
        check("endrop_data", 32'(sample_data), 32'h0E21);
        check("endrop_valid", 32'(sample_valid), 32'd1);
        check("endrop_overrun", 32'(overrun), 32'd0);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (adc_cs_n !== 1'b1 || adc_sclk !== 1'b0) bad++;
        end
        check("idle_after_en_drop", 32'(bad), 32'd0);

        // reset pulsed during bit 8 discards the partial frame
        sample_ready = 1'b1;
        word_q.push_back(16'hFFFF);
        word_q.push_back(16'h4C3A);
        en = 1'b1;
        wait_cs_fall(fall);
        for (int k = 1; k <= DIV + 2 * DIV * 8 + 1; k++) tick();
        reset = 1'b1;
        tick();
        check("midrst_cs_n", 32'(adc_cs_n), 32'd1);
        check("midrst_sclk", 32'(adc_sclk), 32'd0);
        check("midrst_valid", 32'(sample_valid), 32'd0);
        check("midrst_data", 32'(sample_data), 32'd0);
        reset  = 1'b0;
        rst_at = cyc;
        wait_cs_fall(fall);
        check("restart_latency", 32'(fall - rst_at), 32'd1);
        for (int k = 1; k <= LOAD_K; k++) tick();
        check("restart_data", 32'(sample_data), 32'h0C3A);
        check("restart_valid", 32'(sample_valid), 32'd1);

        // random phase: random words, ready, en and rare resets
        for (int i = 0; i < 2000; i++) begin
            sample_ready = 1'($urandom_range(0, 1));
            en           = ($urandom_range(0, 31) != 0);
            reset        = ($urandom_range(0, 599) == 0);
            tick();
        end
        reset = 1'b0;
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
